// File: rtl/gf_syndrome_acc_pkg.sv
// GF(2^M) helpers shared by the syndrome accumulator: multiply-by-alpha,
// constant alpha powers and a default primitive polynomial per field size.
package gf_syndrome_acc_pkg;

    localparam int unsigned GF_MAX_M = 8;

    // One multiply-by-alpha step in GF(2^m): shift left, reduce by poly on carry-out.
    function automatic logic [7:0] gf_mul_alpha(input logic [7:0] x, input int unsigned m,
                                                input logic [8:0] poly);
        logic [7:0] mask;
        logic [7:0] r;
        mask = 8'((9'd1 << m) - 9'd1);
        r    = 8'(x << 1) & mask;
        if (x[3'(m - 1)]) begin
            r = r ^ (poly[7:0] & mask);
        end
        return r;
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int unsigned e, input int unsigned m,
                                                input logic [8:0] poly);
        logic [7:0] r;
        int unsigned ord;
        ord = (32'd1 << m) - 32'd1;
        r   = 8'd1;
        for (int unsigned i = 0; i < e % ord; i++) begin
            r = gf_mul_alpha(r, m, poly);
        end
        return r;
    endfunction

    function automatic logic [8:0] gf_default_poly(input int unsigned m);
        case (m)
            3:       return 9'h00B;
            4:       return 9'h013;
            5:       return 9'h025;
            6:       return 9'h043;
            7:       return 9'h089;
            8:       return 9'h11D;
            default: return 9'h013;
        endcase
    endfunction

endpackage

// File: rtl/gf_cmul_const.sv
// Combinational multiply of a GF(2^M) element by the constant alpha^EXP,
// built as a chain of multiply-by-alpha steps.
module gf_cmul_const
    import gf_syndrome_acc_pkg::*;
#(
    parameter int unsigned M    = 4,
    parameter logic [8:0]  POLY = 9'h013,
    parameter int unsigned EXP  = 1
) (
    input  logic [M-1:0] op,
    output logic [M-1:0] res
);

    localparam int unsigned ORD   = (32'd1 << M) - 32'd1;
    localparam int unsigned EXP_R = EXP % ORD;

    always_comb begin
        res = op;
        for (int unsigned i = 0; i < EXP_R; i++) begin
            res = M'(gf_mul_alpha(8'(res), M, POLY));
        end
    end

endmodule

// File: rtl/gf_syndrome_acc.sv
// Streaming Reed-Solomon syndrome calculator: Horner accumulation of NSYND
// syndromes over framed codewords, registered result one cycle after the last symbol.
module gf_syndrome_acc
    import gf_syndrome_acc_pkg::*;
#(
    parameter int unsigned M     = 4,
    parameter logic [8:0]  POLY  = 9'h013,
    parameter int unsigned NSYM  = 15,
    parameter int unsigned NSYND = 4,
    parameter int unsigned FCR   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sym_valid,
    input  logic                 sym_sof,
    input  logic [M-1:0]         sym,
    output logic [NSYND*M-1:0]   synd,
    output logic                 synd_valid,
    output logic                 err_det,
    output logic                 frame_err
);

    localparam int unsigned CW = $clog2(NSYM);

    logic [CW-1:0]      cnt;
    logic [M-1:0]       acc     [NSYND];
    logic [M-1:0]       mul     [NSYND];
    logic [M-1:0]       acc_nxt [NSYND];
    logic [NSYND*M-1:0] synd_nxt;
    logic               first;
    logic               last;

    for (genvar j = 0; j < int'(NSYND); j++) begin : g_root
        gf_cmul_const #(
            .M   (M),
            .POLY(POLY),
            .EXP (FCR + 32'(j))
        ) u_cmul (
            .op (acc[j]),
            .res(mul[j])
        );
    end

    // A sof always restarts; otherwise the codeword completes on the NSYM-th symbol.
    always_comb begin
        first    = (cnt == '0) || sym_sof;
        last     = !sym_sof && (cnt == CW'(NSYM - 1));
        synd_nxt = '0;
        for (int j = 0; j < int'(NSYND); j++) begin
            acc_nxt[j]          = first ? sym : (mul[j] ^ sym);
            synd_nxt[j*M +: M]  = acc_nxt[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            synd       <= '0;
            synd_valid <= 1'b0;
            err_det    <= 1'b0;
            frame_err  <= 1'b0;
            for (int j = 0; j < int'(NSYND); j++) begin
                acc[j] <= '0;
            end
        end else begin
            synd_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (sym_valid) begin
                for (int j = 0; j < int'(NSYND); j++) begin
                    acc[j] <= acc_nxt[j];
                end
                frame_err <= sym_sof && (cnt != '0);
                if (sym_sof) begin
                    cnt <= CW'(1);
                end else if (last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if (last) begin
                    synd       <= synd_nxt;
                    err_det    <= |synd_nxt;
                    synd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gf_syndrome_acc.sv
// Self-checking bench for gf_syndrome_acc (GF(16), NSYM=15, NSYND=4, FCR=1).
module tb_gf_syndrome_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        sym_valid;
    logic        sym_sof;
    logic [3:0]  sym;
    logic [15:0] synd;
    logic        synd_valid;
    logic        err_det;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fe_seen = 0;
    int fe_exp  = 0;

    typedef struct {
        logic [15:0] synd;
        logic        err;
    } exp_t;

    typedef struct {
        logic [59:0] word;   // first-sent symbol (r14) in [59:56]
        logic [15:0] exp_synd;
        logic        exp_err;
    } vec_t;

    exp_t sb[$];
    int   pulse_cyc[$];
    exp_t mon_e;
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf_syndrome_acc #(
        .M    (4),
        .POLY (9'h013),
        .NSYM (15),
        .NSYND(4),
        .FCR  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym_sof   (sym_sof),
        .sym       (sym),
        .synd      (synd),
        .synd_valid(synd_valid),
        .err_det   (err_det),
        .frame_err (frame_err)
    );

    function automatic logic [3:0] apow(input int e);
        case (e % 15)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h4;  3: return 4'h8;
            4: return 4'h3;  5: return 4'h6;  6: return 4'hC;  7: return 4'hB;
            8: return 4'h5;  9: return 4'hA; 10: return 4'h7; 11: return 4'hE;
            12: return 4'hF; 13: return 4'hD; default: return 4'h9;
        endcase
    endfunction

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // Direct polynomial evaluation S_j = sum r_i * alpha^(j*i).
    function automatic exp_t model(input logic [59:0] w);
        exp_t e;
        logic [3:0] s;
        e.synd = '0;
        for (int j = 1; j <= 4; j++) begin
            s = 4'h0;
            for (int k = 0; k < 15; k++) begin
                s = s ^ gmul(w[59-4*k -: 4], apow(j * (14 - k)));
            end
            e.synd[(j-1)*4 +: 4] = s;
        end
        e.err = |e.synd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic sof);
        @(negedge clk);
        sym_valid = 1'b1;
        sym       = s;
        sym_sof   = sof;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sym_valid = 1'b0;
            sym_sof   = 1'b0;
            sym       = 4'($urandom);
        end
    endtask

    task automatic send_cw(input logic [59:0] w, input bit gaps, input bit sof_first);
        for (int k = 0; k < 15; k++) begin
            if (gaps) idle(int'($urandom_range(0, 3)));
            drive(w[59-4*k -: 4], sof_first && (k == 0));
        end
        sb.push_back(model(w));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: every synd_valid pulse pops one expected result.
    always @(negedge clk) begin
        if (frame_err) fe_seen++;
        if (synd_valid) begin
            pulse_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got synd=%h with nothing expected", synd);
            end else begin
                mon_e = sb.pop_front();
                if (synd !== mon_e.synd || err_det !== mon_e.err) begin
                    errors++;
                    $display("FAIL synd: got %h/%b expected %h/%b", synd, err_det,
                             mon_e.synd, mon_e.err);
                end
            end
        end
    end

    initial begin
        int n0;
        int n;
        exp_t e;
        rst = 1'b1; sym_valid = 1'b0; sym_sof = 1'b0; sym = 4'h0;

        vecs[0] = '{60'h0,               16'h0000, 1'b0};
        vecs[1] = '{60'h000000000000001, 16'h1111, 1'b1};
        vecs[2] = '{60'h100000000000000, 16'hEFD9, 1'b1};
        for (int i = 3; i < 6; i++) begin
            vecs[i].word = 60'({$urandom, $urandom});
            e = model(vecs[i].word);
            vecs[i].exp_synd = e.synd;
            vecs[i].exp_err  = e.err;
        end

        repeat (3) @(negedge clk);
        chk("rst_synd", 32'(synd), 32'd0);
        chk("rst_valid", 32'(synd_valid), 32'd0);
        chk("rst_err", 32'(err_det), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        idle(2);

        // Table vectors; the model must also agree with the hand-derived constants.
        for (int i = 0; i < 6; i++) begin
            e = model(vecs[i].word);
            chk("table_model", {15'd0, e.err, e.synd}, {15'd0, vecs[i].exp_err, vecs[i].exp_synd});
            send_cw(vecs[i].word, 1'b0, i[0]);
            idle(2);
        end
        drain();

        // sof mid-codeword: discard partial, pulse frame_err, restart with this symbol.
        for (int k = 0; k < 7; k++) drive(4'($urandom_range(1, 15)), 1'b0);
        drive(4'h0, 1'b1);
        fe_exp++;
        drive(4'h0, 1'b0);
        chk("frame_err_pulse", 32'(frame_err), 32'd1);
        for (int k = 0; k < 13; k++) drive(4'h0, 1'b0);
        sb.push_back('{16'h0000, 1'b0});
        idle(3);
        drain();

        // Random gaps, then a back-to-back codeword with no bubble.
        n0 = pulse_cyc.size();
        send_cw(vecs[2].word, 1'b1, 1'b0);
        send_cw(vecs[2].word, 1'b0, 1'b0);
        idle(4);
        drain();
        n = pulse_cyc.size();
        chk("b2b_pulses", 32'(n - n0), 32'd2);
        if (n >= 2) chk("b2b_spacing", 32'(pulse_cyc[n-1] - pulse_cyc[n-2]), 32'd15);
        chk("hold_synd", 32'(synd), 32'h0000EFD9);
        chk("hold_valid", 32'(synd_valid), 32'd0);
        chk("hold_err", 32'(err_det), 32'd1);

        // Reset mid-codeword drops the partial and clears outputs immediately.
        for (int k = 0; k < 9; k++) drive(4'($urandom_range(1, 15)), 1'b0);
        @(negedge clk);
        sym_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_synd", 32'(synd), 32'd0);
        chk("mid_rst_err", 32'(err_det), 32'd0);
        chk("mid_rst_valid", 32'(synd_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_cw(vecs[1].word, 1'b0, 1'b0);
        idle(3);
        drain();
        send_cw(vecs[4].word, 1'b1, 1'b0);
        idle(3);
        drain();

        chk("frame_err_count", 32'(fe_seen), 32'(fe_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
